// File: rtl/vram_scanout.sv
// ---------------------------------------------------------------------------
// vram_scanout
//
// VGA-style raster scanout engine reading a linear RGB565 framebuffer.
// Horizontal/vertical counters walk the raster.  During the visible area a
// read strobe and an incrementing linear address are issued every clock.
// The framebuffer answers RD_LAT clocks later.  Sync and active flags are
// delayed to line up with the returned pixel.  Colour and sync are then
// registered together in one final stage.
//
// Ports
//   clk         pixel clock (single domain)
//   rst         asynchronous, active-high reset
//   rd_addr     framebuffer read address, y*H_ACTIVE+x
//   rd_en       read strobe, high only for visible-area reads
//   rd_data     RGB565 pixel, valid RD_LAT clocks after its rd_en
//   vga_r/g/b   4-bit colour, forced to 0 outside the visible area
//   vga_hs/vs   active-low syncs, aligned with colour
//   vblank      high while the vertical counter is in the blanking region
//   frame_start one-clock pulse on the first clock of line 0, pixel 0
//
// RD_LAT must lie in 1..4.
// ---------------------------------------------------------------------------
module vram_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [18:0] rd_addr,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0]   ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    logic              run_q, run_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [18:0]       addr_q, addr_d;
    logic [RD_LAT-1:0] act_pipe_q, act_pipe_d;
    logic [RD_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [RD_LAT-1:0] vs_pipe_q, vs_pipe_d;
    logic [3:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              hs_out_q, hs_out_d;
    logic              vs_out_q, vs_out_d;
    logic              vblank_q, vblank_d;
    logic              fs_q, fs_d;

    logic active;
    logic hs_raw;
    logic vs_raw;
    logic frame_wrap;
    logic pix_active;
    logic unused_rd_bits;

    // The RGB565 low-order bits of each channel are dropped by the 4-bit DAC.
    assign unused_rd_bits = ^{rd_data[11], rd_data[6:5], rd_data[0]};

    // Raster counters.  run_q stays low through reset and for the release
    // cycle, so the first clock edge after release re-loads 0/0 instead of
    // advancing.  That makes the first clock visible after release the
    // pixel 0 of line 0 clock, with frame_start pulsing and a full first line.
    always_comb begin
        run_d  = 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (run_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Visible-area decode, raw syncs and the linear read address.  The address
    // stops at the last pixel, so it never leaves the framebuffer while it
    // idles through vertical blanking.  It restarts when the raster wraps.
    always_comb begin
        active     = run_q && (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        hs_raw     = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
        vs_raw     = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));
        frame_wrap = (hcnt_d == '0) && (vcnt_d == '0);
        addr_d     = addr_q;
        if (frame_wrap) begin
            addr_d = '0;
        end else if (active && (addr_q != ADDR_LAST)) begin
            addr_d = addr_q + 19'd1;
        end
        vblank_d = (vcnt_d >= V_VIS);
        fs_d     = frame_wrap;
    end

    // Delay lines RD_LAT deep.  The last stage lines up with rd_data.
    always_comb begin
        act_pipe_d    = act_pipe_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        act_pipe_d[0] = active;
        hs_pipe_d[0]  = hs_raw;
        vs_pipe_d[0]  = vs_raw;
        for (int i = 1; i < RD_LAT; i++) begin
            act_pipe_d[i] = act_pipe_q[i-1];
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
        end
    end

    // Output stage.  rd_data is looked at only when the delayed active flag
    // says it belongs to a visible pixel.  Sync goes through the same
    // register so that it has zero skew against colour.
    always_comb begin
        pix_active = act_pipe_q[RD_LAT-1];
        r_d        = pix_active ? rd_data[15:12] : 4'h0;
        g_d        = pix_active ? rd_data[10:7]  : 4'h0;
        b_d        = pix_active ? rd_data[4:1]   : 4'h0;
        hs_out_d   = hs_pipe_q[RD_LAT-1];
        vs_out_d   = vs_pipe_q[RD_LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            addr_q     <= '0;
            act_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            r_q        <= 4'h0;
            g_q        <= 4'h0;
            b_q        <= 4'h0;
            hs_out_q   <= 1'b1;
            vs_out_q   <= 1'b1;
            vblank_q   <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            run_q      <= run_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            addr_q     <= addr_d;
            act_pipe_q <= act_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
            vblank_q   <= vblank_d;
            fs_q       <= fs_d;
        end
    end

    assign rd_en       = active;
    assign rd_addr     = addr_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_out_q;
    assign vga_vs      = vs_out_q;
    assign vblank      = vblank_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// ---------------------------------------------------------------------------
// tb_vram_scanout
//
// Self-checking bench for vram_scanout using a reduced raster so that whole
// frames are short.  A behavioural raster model pushes the expected pixel and
// sync for every clock into a queue.  Entries are popped RD_LAT+1 clocks
// later against the DUT outputs.  Scenario tasks add their own targeted
// checks on periods, the address sweep, latency, colour mapping, vblank
// and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_vram_scanout;

    localparam int HA     = 16;
    localparam int HFP    = 2;
    localparam int HSW    = 4;
    localparam int HBP    = 3;
    localparam int VA     = 12;
    localparam int VFP    = 2;
    localparam int VSW    = 2;
    localparam int VBP    = 3;
    localparam int RD_LAT = 2;
    localparam int HT     = HA + HFP + HSW + HBP;
    localparam int VT     = VA + VFP + VSW + VBP;
    localparam int FRAME  = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vblank, frame_start;

    int total = 0;
    int bad   = 0;

    logic [18:0] special_addr = 19'h7FFFF;

    vram_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Framebuffer contents: the low address bits, except one pixel that can
    // be turned into a magenta test colour.
    function automatic logic [15:0] vram(input logic [18:0] a);
        return (a == special_addr) ? 16'hF81F : a[15:0];
    endfunction

    function automatic logic [11:0] rgb(input logic [15:0] d);
        return {d[15:12], d[10:7], d[4:1]};
    endfunction

    // VRAM model: answers exactly RD_LAT clocks after a strobe and drives
    // garbage otherwise.
    logic [18:0] ap [RD_LAT];
    logic        ep [RD_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ap[i] <= '0;
                ep[i] <= 1'b0;
            end
        end else begin
            ap[0] <= rd_addr;
            ep[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                ap[i] <= ap[i-1];
                ep[i] <= ep[i-1];
            end
        end
    end
    assign rd_data = ep[RD_LAT-1] ? vram(ap[RD_LAT-1]) : 16'hBEEF;

    // Raster model: after reset release the first clock edge lands on line 0,
    // pixel 0, and the raster then advances every clock.
    int   mh = 0;
    int   mv = 0;
    logic mlive = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mlive = 1'b0;
            mh    = 0;
            mv    = 0;
        end else if (!mlive) begin
            mlive = 1'b1;
        end else if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    end

    // Scoreboard: push the expected {r,g,b,hs,vs} for this clock and pop the
    // entry pushed RD_LAT+1 clocks ago.  The first RD_LAT+1 entries are the
    // idle values left by reset.
    logic [13:0] sb_q [$];
    always @(negedge clk) begin
        logic [13:0] exp_e;
        logic [13:0] got_e;
        logic        m_act;
        logic        m_hs;
        logic        m_vs;
        logic [18:0] m_addr;
        if (rst || !mlive) begin
            sb_q.delete();
        end else begin
            if (sb_q.size() == 0) begin
                repeat (RD_LAT + 1) sb_q.push_back(14'b00000000000011);
            end
            m_act  = (mh < HA) && (mv < VA);
            m_addr = 19'(mv * HA + mh);
            m_hs   = !((mh >= HA + HFP) && (mh < HA + HFP + HSW));
            m_vs   = !((mv >= VA + VFP) && (mv < VA + VFP + VSW));
            exp_e  = {(m_act ? rgb(vram(m_addr)) : 12'h000), m_hs, m_vs};
            sb_q.push_back(exp_e);
            exp_e = sb_q.pop_front();
            got_e = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
            total++;
            if (got_e !== exp_e) begin
                bad++;
                $display("[TB] FAIL sb_pixel h=%0d v=%0d: got %h want %h", mh, mv, got_e, exp_e);
            end
            total++;
            if (rd_en !== m_act) begin
                bad++;
                $display("[TB] FAIL sb_rd_en h=%0d v=%0d: got %b want %b", mh, mv, rd_en, m_act);
            end
            total++;
            if (frame_start !== (mh == 0 && mv == 0)) begin
                bad++;
                $display("[TB] FAIL sb_frame_start h=%0d v=%0d: got %b", mh, mv, frame_start);
            end
            total++;
            if (vblank !== (mv >= VA)) begin
                bad++;
                $display("[TB] FAIL sb_vblank h=%0d v=%0d: got %b", mh, mv, vblank);
            end
            if (m_act) begin
                total++;
                if (rd_addr !== m_addr) begin
                    bad++;
                    $display("[TB] FAIL sb_rd_addr h=%0d v=%0d: got %0d want %0d", mh, mv, rd_addr, m_addr);
                end
            end
        end
    end

    task automatic wait_fs(output logic found);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10 && !found; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({rd_addr, rd_en, vga_r, vga_g, vga_b} !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got addr=%0d en=%b rgb=%h%h%h want 0", rd_addr, rd_en, vga_r, vga_g, vga_b);
        end
        total++;
        if ({vga_hs, vga_vs, vblank, frame_start} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 1100", {vga_hs, vga_vs, vblank, frame_start});
        end
        rst = 1'b0;
        #1;
        total++;
        if ({rd_en, frame_start} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL release_idle: got %b want 00", {rd_en, frame_start});
        end
        @(negedge clk);
        total++;
        if ({frame_start, rd_en, rd_addr} !== {1'b1, 1'b1, 19'd0}) begin
            bad++;
            $display("[TB] FAIL first_clock: got fs=%b en=%b addr=%0d want 1 1 0", frame_start, rd_en, rd_addr);
        end
    endtask

    task automatic test_counters();
        int   hs_fall [$];
        int   vs_fall [$];
        int   fs_at [$];
        int   hs_run, vs_run, hs_low, vs_low, hs_per, vs_per, fs_per;
        logic phs, pvs;
        hs_run = 0; vs_run = 0; hs_low = -1; vs_low = -1;
        @(negedge clk);
        phs = vga_hs;
        pvs = vga_vs;
        for (int c = 0; c < 2 * FRAME + HT; c++) begin
            @(negedge clk);
            if (phs && !vga_hs) hs_fall.push_back(c);
            if (pvs && !vga_vs) vs_fall.push_back(c);
            if (frame_start === 1'b1) fs_at.push_back(c);
            if (!vga_hs) hs_run++;
            else begin
                if (!phs) hs_low = hs_run;
                hs_run = 0;
            end
            if (!vga_vs) vs_run++;
            else begin
                if (!pvs) vs_low = vs_run;
                vs_run = 0;
            end
            phs = vga_hs;
            pvs = vga_vs;
        end
        hs_per = (hs_fall.size() >= 2) ? hs_fall[$] - hs_fall[$-1] : -1;
        vs_per = (vs_fall.size() >= 2) ? vs_fall[$] - vs_fall[$-1] : -1;
        fs_per = (fs_at.size() >= 2) ? fs_at[$] - fs_at[$-1] : -1;
        total++;
        if (hs_per !== HT) begin bad++; $display("[TB] FAIL hs_period: got %0d want %0d", hs_per, HT); end
        total++;
        if (hs_low !== HSW) begin bad++; $display("[TB] FAIL hs_low: got %0d want %0d", hs_low, HSW); end
        total++;
        if (vs_per !== FRAME) begin bad++; $display("[TB] FAIL vs_period: got %0d want %0d", vs_per, FRAME); end
        total++;
        if (vs_low !== VSW * HT) begin bad++; $display("[TB] FAIL vs_low: got %0d want %0d", vs_low, VSW * HT); end
        total++;
        if (fs_per !== FRAME) begin bad++; $display("[TB] FAIL fs_period: got %0d want %0d", fs_per, FRAME); end
    endtask

    task automatic test_address_sweep();
        logic found;
        int   cnt, gaps;
        logic [18:0] exp_next;
        wait_fs(found);
        total++;
        if (found !== 1'b1) begin bad++; $display("[TB] FAIL sweep_fs: got timeout want frame_start"); end
        cnt = 0; gaps = 0; exp_next = '0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (rd_en === 1'b1) begin
                cnt++;
                if (rd_addr !== exp_next) gaps++;
                exp_next = exp_next + 19'd1;
            end
            if ((k % HT) == 0 && (k / HT) < VA) begin
                total++;
                if (rd_addr !== 19'(HA * (k / HT))) begin
                    bad++;
                    $display("[TB] FAIL line_start y=%0d: got %0d want %0d", k / HT, rd_addr, HA * (k / HT));
                end
            end
        end
        total++;
        if (cnt !== HA * VA) begin bad++; $display("[TB] FAIL rd_en_count: got %0d want %0d", cnt, HA * VA); end
        total++;
        if (gaps !== 0) begin bad++; $display("[TB] FAIL addr_contig: got %0d breaks want 0", gaps); end
    endtask

    task automatic test_latency();
        logic found;
        wait_fs(found);
        total++;
        if (found !== 1'b1) begin bad++; $display("[TB] FAIL lat_fs: got timeout want frame_start"); end
        for (int k = 0; k <= HA + RD_LAT + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 5) begin
                total++;
                if ({rd_en, rd_addr} !== {1'b1, 19'd5}) begin
                    bad++;
                    $display("[TB] FAIL lat_read: got en=%b addr=%0d want 1 5", rd_en, rd_addr);
                end
            end
            if (k == 5 + RD_LAT + 1) begin
                total++;
                if ({vga_r, vga_g, vga_b} !== rgb(16'd5)) begin
                    bad++;
                    $display("[TB] FAIL lat_colour: got %h want %h", {vga_r, vga_g, vga_b}, rgb(16'd5));
                end
            end
            if (k == HA + RD_LAT) begin
                total++;
                if ({vga_r, vga_g, vga_b} !== rgb(16'(HA - 1))) begin
                    bad++;
                    $display("[TB] FAIL last_pixel: got %h want %h", {vga_r, vga_g, vga_b}, rgb(16'(HA - 1)));
                end
            end
            if (k == HA + RD_LAT + 1) begin
                total++;
                if ({vga_r, vga_g, vga_b} !== 12'h000) begin
                    bad++;
                    $display("[TB] FAIL porch_black: got %h want 000", {vga_r, vga_g, vga_b});
                end
            end
        end
    endtask

    task automatic test_colour();
        logic found;
        int   kp;
        wait_fs(found);
        total++;
        if (found !== 1'b1) begin bad++; $display("[TB] FAIL col_fs: got timeout want frame_start"); end
        special_addr = 19'(2 * HA + 3);
        kp = 2 * HT + 3;
        for (int k = 0; k <= kp + RD_LAT + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (k == kp) begin
                total++;
                if ({rd_en, rd_addr} !== {1'b1, 19'(2 * HA + 3)}) begin
                    bad++;
                    $display("[TB] FAIL col_read: got en=%b addr=%0d want 1 %0d", rd_en, rd_addr, 2 * HA + 3);
                end
            end
            if (k == kp + RD_LAT + 1) begin
                total++;
                if ({vga_r, vga_g, vga_b} !== 12'hF0F) begin
                    bad++;
                    $display("[TB] FAIL magenta: got %h want F0F", {vga_r, vga_g, vga_b});
                end
            end
            if (k == kp + RD_LAT + 2) begin
                total++;
                if ({vga_r, vga_g, vga_b} !== rgb(16'(2 * HA + 4))) begin
                    bad++;
                    $display("[TB] FAIL after_magenta: got %h want %h", {vga_r, vga_g, vga_b}, rgb(16'(2 * HA + 4)));
                end
            end
        end
    endtask

    task automatic test_vblank();
        logic found;
        logic vb_before;
        int   rise_k, viol;
        wait_fs(found);
        total++;
        if ({found, vblank} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL vb_at_fs: got found=%b vblank=%b want 1 0", found, vblank);
        end
        rise_k = -1; viol = 0; vb_before = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (vblank === 1'b1 && rise_k < 0) rise_k = k;
            if (vblank === 1'b1 && rd_en !== 1'b0) viol++;
            if (k == FRAME - 1) vb_before = vblank;
            if (k == FRAME) begin
                total++;
                if ({frame_start, vblank, vb_before} !== 3'b101) begin
                    bad++;
                    $display("[TB] FAIL vb_fall: got fs=%b vb=%b prev=%b want 1 0 1", frame_start, vblank, vb_before);
                end
            end
        end
        total++;
        if (rise_k !== VA * HT) begin bad++; $display("[TB] FAIL vb_rise: got %0d want %0d", rise_k, VA * HT); end
        total++;
        if (viol !== 0) begin bad++; $display("[TB] FAIL vb_reads: got %0d want 0", viol); end
    endtask

    task automatic test_reset_mid_frame();
        logic found;
        wait_fs(found);
        total++;
        if (found !== 1'b1) begin bad++; $display("[TB] FAIL mid_fs: got timeout want frame_start"); end
        repeat ((VA / 2) * HT + HA / 2 + 2) @(negedge clk);
        total++;
        if ({rd_en, rd_addr} !== {1'b1, 19'((VA / 2) * HA + HA / 2 + 2)}) begin
            bad++;
            $display("[TB] FAIL mid_pre: got en=%b addr=%0d want 1 %0d", rd_en, rd_addr, (VA / 2) * HA + HA / 2 + 2);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({rd_addr, rd_en, vga_r, vga_g, vga_b} !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mid_rst_data: got addr=%0d en=%b rgb=%h%h%h want 0", rd_addr, rd_en, vga_r, vga_g, vga_b);
        end
        total++;
        if ({vga_hs, vga_vs, vblank, frame_start} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL mid_rst_ctrl: got %b want 1100", {vga_hs, vga_vs, vblank, frame_start});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({frame_start, rd_en, rd_addr} !== {1'b1, 1'b1, 19'd0}) begin
            bad++;
            $display("[TB] FAIL mid_restart: got fs=%b en=%b addr=%0d want 1 1 0", frame_start, rd_en, rd_addr);
        end
        @(negedge clk);
        total++;
        if ({frame_start, rd_addr} !== {1'b0, 19'd1}) begin
            bad++;
            $display("[TB] FAIL mid_second: got fs=%b addr=%0d want 0 1", frame_start, rd_addr);
        end
        repeat (FRAME + 10) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_counters();
        test_address_sweep();
        test_latency();
        test_colour();
        test_vblank();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
